// File: rtl/seg7_scan_driver_pkg.sv
// Shared glyph codes and seven-segment patterns for the display path.
// The suspense/result stage emits these codes; the scan driver decodes them.
package seg7_scan_driver_pkg;

    // Glyph codes carried on d1..d4
    localparam logic [3:0] GL_0    = 4'h0;
    localparam logic [3:0] GL_1    = 4'h1;
    localparam logic [3:0] GL_2    = 4'h2;
    localparam logic [3:0] GL_3    = 4'h3;
    localparam logic [3:0] GL_P    = 4'h4;
    localparam logic [3:0] GL_R    = 4'h5;
    localparam logic [3:0] GL_S    = 4'h6;
    localparam logic [3:0] GL_DASH = 4'h7;
    localparam logic [3:0] GL_ERR  = 4'h8;
    localparam logic [3:0] GL_OFF  = 4'hF;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_P     = 7'b0001100;
    localparam logic [6:0] SEG_R     = 7'b0101111;
    localparam logic [6:0] SEG_S     = 7'b0010010;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_ERR   = 7'b0000110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_ALL_OFF = 4'b1111;

    // Digit slot currently being driven; DIG0 is the leftmost digit
    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } digit_e;

    // Counter width for a modulus, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Active-low anode pattern for a digit slot; an[3] is the leftmost digit
    function automatic logic [3:0] anode_sel(input digit_e dig);
        logic [3:0] an;
        an = AN_ALL_OFF;
        case (dig)
            DIG0:    an = 4'b0111;
            DIG1:    an = 4'b1011;
            DIG2:    an = 4'b1101;
            DIG3:    an = 4'b1110;
            default: an = AN_ALL_OFF;
        endcase
        return an;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_glyph_decode.sv
// Combinational glyph code to active-low seven-segment pattern decoder.
module seg7_glyph_decode
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    // Map each glyph code to its segment pattern; unknown codes are blank
    always_comb begin
        seg_o = SEG_BLANK;
        case (code_i)
            GL_0:    seg_o = SEG_0;
            GL_1:    seg_o = SEG_1;
            GL_2:    seg_o = SEG_2;
            GL_3:    seg_o = SEG_3;
            GL_P:    seg_o = SEG_P;
            GL_R:    seg_o = SEG_R;
            GL_S:    seg_o = SEG_S;
            GL_DASH: seg_o = SEG_DASH;
            GL_ERR:  seg_o = SEG_ERR;
            GL_OFF:  seg_o = SEG_BLANK;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver with per-frame snapshot,
// anti-ghosting blanking at the start of each slot and an all-error blink.
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 500,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic [3:0] d4,
    input  logic       blink_en,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int SCAN_W  = cnt_width(REFRESH_DIV);
    localparam int BLINK_W = cnt_width(BLINK_DIV);

    logic [SCAN_W-1:0]  scan_cnt_q,  scan_cnt_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;
    digit_e             idx_q, idx_d;
    // Element 0 holds d1 (leftmost), element 3 holds d4 (rightmost)
    logic [3:0][3:0]    shadow_q, shadow_d;
    logic [3:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;

    logic               scan_wrap;
    logic               blink_wrap;
    logic               frame_start;
    logic               in_blank;
    logic               all_err;
    logic               blink_hide;
    logic [3:0]         code_mux;
    logic [6:0]         seg_dec;

    assign scan_wrap   = (scan_cnt_q == SCAN_W'(REFRESH_DIV - 1));
    assign blink_wrap  = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));
    assign frame_start = (scan_cnt_q == '0) && (idx_q == DIG0);
    assign in_blank    = (scan_cnt_q < SCAN_W'(BLANK_CYC));
    assign all_err     = (shadow_q[0] == GL_ERR) && (shadow_q[1] == GL_ERR) &&
                         (shadow_q[2] == GL_ERR) && (shadow_q[3] == GL_ERR);
    assign blink_hide  = blink_en && all_err && blink_phase_q;
    assign code_mux    = shadow_q[idx_q];

    seg7_glyph_decode u_decode (
        .code_i (code_mux),
        .seg_o  (seg_dec)
    );

    // Next-state for the slot/frame counters, blink timer and input snapshot
    always_comb begin
        scan_cnt_d    = scan_cnt_q + SCAN_W'(1);
        idx_d         = idx_q;
        blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
        blink_phase_d = blink_phase_q;
        shadow_d      = shadow_q;
        if (scan_wrap) begin
            scan_cnt_d = '0;
            idx_d      = digit_e'(idx_q + 2'd1);
        end
        if (blink_wrap) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end
        if (frame_start) begin
            shadow_d = {d4, d3, d2, d1};
        end
    end

    // Next display outputs: blank during the guard window or a blink-off phase
    always_comb begin
        an_d  = AN_ALL_OFF;
        seg_d = SEG_BLANK;
        if (!in_blank && !blink_hide) begin
            an_d  = anode_sel(idx_q);
            seg_d = seg_dec;
        end
    end

    // Counter, blink and snapshot state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q    <= '0;
            idx_q         <= DIG0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            shadow_q      <= {4{GL_OFF}};
        end else begin
            scan_cnt_q    <= scan_cnt_d;
            idx_q         <= idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            shadow_q      <= shadow_d;
        end
    end

    // Registered display outputs, one cycle behind the scan state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q  <= AN_ALL_OFF;
            seg_q <= SEG_BLANK;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = 1'b1;

endmodule
